// File: rtl/video_timing.sv
// +----------------------------------------------------------------------------+
// | video_timing: raster counters, x/y decode for the overlay, and sync/DE     |
// | delayed to line up with the overlay's pixel_data_in return.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module video_timing #(
    parameter int unsigned H_ACTIVE      = 800,
    parameter int unsigned H_FP          = 40,
    parameter int unsigned H_SYNC        = 128,
    parameter int unsigned H_BP          = 88,
    parameter int unsigned V_ACTIVE      = 600,
    parameter int unsigned V_FP          = 1,
    parameter int unsigned V_SYNC        = 4,
    parameter int unsigned V_BP          = 23,
    parameter bit          HSYNC_POL     = 1'b1,
    parameter bit          VSYNC_POL     = 1'b1,
    parameter int unsigned PIXEL_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    input  logic [2:0] pixel_data_in,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [2:0] rgb,
    output logic       frame_start
);

    localparam logic [10:0] c_H_ACTIVE   = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] c_V_ACTIVE   = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] c_V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    generate
        if (PIXEL_LATENCY > 7 || H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_param_check
            $error("video_timing: PIXEL_LATENCY must be 0..7 and H_ACTIVE/V_ACTIVE <= 1024");
        end
    endgenerate

    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [2:0]  r_rgb;
    logic        r_frame_start;

    logic        w_h_active;
    logic        w_v_active;
    logic [2:0]  w_sync_raw;
    logic [2:0]  w_sync_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 11'd1;
        end
    end

    assign w_h_active = (r_h_cnt < c_H_ACTIVE);
    assign w_v_active = (r_v_cnt < c_V_ACTIVE);

    assign active = w_h_active && w_v_active;
    assign x      = w_h_active ? r_h_cnt[9:0] : 10'd0;
    assign y      = w_v_active ? r_v_cnt[9:0] : 10'd0;

    // Pipeline carries polarity-free "asserted" flags: {hsync, vsync, de}.
    assign w_sync_raw = {(r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END),
                         (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END),
                         w_h_active && w_v_active};

    generate
        if (PIXEL_LATENCY == 0) begin : g_no_delay
            assign w_sync_dly = w_sync_raw;
        end else begin : g_delay
            logic [2:0] r_pipe [0:PIXEL_LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIXEL_LATENCY; i++) begin
                        r_pipe[i] <= 3'b000;
                    end
                end else begin
                    r_pipe[0] <= w_sync_raw;
                    for (int i = 1; i < PIXEL_LATENCY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_sync_dly = r_pipe[PIXEL_LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b0;
            r_rgb         <= 3'b000;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_sync_dly[2] ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_sync_dly[1] ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= w_sync_dly[0];
            r_rgb         <= w_sync_dly[0] ? pixel_data_in : 3'b000;
            // Fires on the wrap into (0,0), so never for the origin held by reset.
            r_frame_start <= (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_LAST);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire
